// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the write-back path.
// icodes, register ids, status codes and scheduler state.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [1:0] SAOK = 2'd1;
  localparam logic [1:0] SHLT = 2'd2;
  localparam logic [1:0] SADR = 2'd3;

  typedef enum logic {
    IDLE,
    SECOND
  } wb_state_e;

  // RNONE maps to an empty mask
  function automatic logic [14:0] reg_mask(
    input logic [3:0] r
  );
    logic [14:0] m;
    m = '0;
    if (r != RNONE) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/y86_dst_decode.sv
// Destination register decode (dstE/dstM) for a Y86-64 instruction.
// Shared by write-back scheduling and decode-stage forwarding.
module y86_dst_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  input  logic       cnd_i,
  input  logic [3:0] ra_i,
  input  logic [3:0] rb_i,
  output logic [3:0] dst_e_o,
  output logic [3:0] dst_m_o
);

  always_comb begin
    dst_e_o = RNONE;
    unique case (1'b1)
      (icode_i == IIRMOVQ),
      (icode_i == IOPQ):
        dst_e_o = rb_i;
      (icode_i == IRRMOVQ):
        dst_e_o = cnd_i ? rb_i : RNONE;
      (icode_i == ICALL),
      (icode_i == IRET),
      (icode_i == IPUSHQ),
      (icode_i == IPOPQ):
        dst_e_o = RRSP;
      default:
        dst_e_o = RNONE;
    endcase
  end

  always_comb begin
    dst_m_o = RNONE;
    unique case (1'b1)
      (icode_i == IMRMOVQ),
      (icode_i == IPOPQ):
        dst_m_o = ra_i;
      default:
        dst_m_o = RNONE;
    endcase
  end

endmodule

// File: rtl/y86_rf_write_sched.sv
// Write-back scheduler: drives the single RF write port,
// splitting dual-write instructions into E then M.
module y86_rf_write_sched
  import y86_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [3:0]    w_icode,
  input  logic          w_cnd,
  input  logic [AW-1:0] w_rA,
  input  logic [AW-1:0] w_rB,
  input  logic [DW-1:0] w_valE,
  input  logic [DW-1:0] w_valM,
  input  logic [1:0]    w_stat,
  input  logic          w_stat_ins,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [14:0]   wr_pending,
  output logic          halted
);

  wb_state_e     state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic [14:0]   pend_q, pend_d;
  logic          halted_q, halted_d;

  logic [AW-1:0] dst_e, dst_m;
  logic          accept, bad;

  y86_dst_decode u_dec (
    .icode_i (w_icode),
    .cnd_i   (w_cnd),
    .ra_i    (w_rA),
    .rb_i    (w_rB),
    .dst_e_o (dst_e),
    .dst_m_o (dst_m)
  );

  assign w_ready = (state_q == IDLE) && !halted_q;
  assign accept  = w_valid && w_ready;
  assign bad     = (w_stat != SAOK) || w_stat_ins;

  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    halted_d    = halted_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad) begin
            halted_d = 1'b1;
          end else if (dst_e != RNONE && dst_m != RNONE) begin
            if (dst_e == dst_m) begin
              we_d    = 1'b1;
              waddr_d = dst_m;
              wdata_d = w_valM;
            end else begin
              we_d        = 1'b1;
              waddr_d     = dst_e;
              wdata_d     = w_valE;
              hold_addr_d = dst_m;
              hold_data_d = w_valM;
              state_d     = SECOND;
            end
          end else if (dst_e != RNONE) begin
            we_d    = 1'b1;
            waddr_d = dst_e;
            wdata_d = w_valE;
          end else if (dst_m != RNONE) begin
            we_d    = 1'b1;
            waddr_d = dst_m;
            wdata_d = w_valM;
          end
        end
      end
      SECOND: begin
        we_d    = 1'b1;
        waddr_d = hold_addr_q;
        wdata_d = hold_data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // clear first so a coincident new set survives
  always_comb begin
    pend_d = pend_q;
    if (we_q) pend_d = pend_d & ~reg_mask(waddr_q);
    if (accept && !bad)
      pend_d = pend_d | reg_mask(dst_e) | reg_mask(dst_m);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      waddr_q     <= RNONE;
      wdata_q     <= '0;
      hold_addr_q <= RNONE;
      hold_data_q <= '0;
      pend_q      <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      pend_q      <= pend_d;
      halted_q    <= halted_d;
    end
  end

  assign rf_we      = we_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign wr_pending = pend_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_y86_rf_write_sched.sv
// Directed bench for the Y86-64 write-back scheduler.
// Inputs change 1ns after posedge; outputs sampled there too.
module tb_y86_rf_write_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_valid;
  logic        w_ready;
  logic [3:0]  w_icode;
  logic        w_cnd;
  logic [3:0]  w_rA;
  logic [3:0]  w_rB;
  logic [63:0] w_valE;
  logic [63:0] w_valM;
  logic [1:0]  w_stat;
  logic        w_stat_ins;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [14:0] wr_pending;
  logic        halted;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  y86_rf_write_sched dut (
    .clk        (clk),
    .reset      (reset),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_icode    (w_icode),
    .w_cnd      (w_cnd),
    .w_rA       (w_rA),
    .w_rB       (w_rB),
    .w_valE     (w_valE),
    .w_valM     (w_valM),
    .w_stat     (w_stat),
    .w_stat_ins (w_stat_ins),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .wr_pending (wr_pending),
    .halted     (halted)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic [3:0]  ic,
    input logic        cnd,
    input logic [3:0]  ra,
    input logic [3:0]  rb,
    input logic [63:0] ve,
    input logic [63:0] vm,
    input logic [1:0]  st,
    input logic        ins
  );
    w_valid    = 1'b1;
    w_icode    = ic;
    w_cnd      = cnd;
    w_rA       = ra;
    w_rB       = rb;
    w_valE     = ve;
    w_valM     = vm;
    w_stat     = st;
    w_stat_ins = ins;
    step();
    w_valid = 1'b0;
  endtask

  task automatic wr(
    input string       tag,
    input logic        we,
    input logic [3:0]  a,
    input logic [63:0] d,
    input logic [14:0] p
  );
    check({tag, ".we"}, 64'(rf_we), 64'(we));
    if (we) begin
      check({tag, ".addr"}, 64'(rf_waddr), 64'(a));
      check({tag, ".data"}, rf_wdata, d);
    end
    check({tag, ".pend"}, 64'(wr_pending), 64'(p));
  endtask

  initial begin
    reset = 1'b1;
    w_valid = 1'b0;
    w_icode = 4'h1;
    w_cnd = 1'b0;
    w_rA = 4'hF;
    w_rB = 4'hF;
    w_valE = '0;
    w_valM = '0;
    w_stat = 2'd1;
    w_stat_ins = 1'b0;
    step();
    step();
    check("rst.we", 64'(rf_we), 64'd0);
    check("rst.addr", 64'(rf_waddr), 64'hF);
    check("rst.data", rf_wdata, 64'd0);
    check("rst.pend", 64'(wr_pending), 64'd0);
    check("rst.halted", 64'(halted), 64'd0);
    reset = 1'b0;
    step();
    check("rst.ready", 64'(w_ready), 64'd1);

    // irmovq $0x2A, %rdx
    issue(4'h3, 1'b0, 4'hF, 4'h2, 64'h2A, 64'h0, 2'd1, 1'b0);
    wr("irm.n1", 1'b1, 4'h2, 64'h2A, 15'h0004);
    step();
    wr("irm.n2", 1'b0, 4'h0, 64'h0, 15'h0000);
    check("irm.hold", 64'(rf_waddr), 64'h2);

    // popq %rbx: E then M
    issue(4'hB, 1'b0, 4'h3, 4'hF, 64'h1008, 64'h55, 2'd1, 1'b0);
    wr("pop.n1", 1'b1, 4'h4, 64'h1008, 15'h0018);
    check("pop.n1.ready", 64'(w_ready), 64'd0);
    step();
    wr("pop.n2", 1'b1, 4'h3, 64'h55, 15'h0008);
    check("pop.n2.ready", 64'(w_ready), 64'd1);
    step();
    wr("pop.n3", 1'b0, 4'h0, 64'h0, 15'h0000);

    // popq %rsp: M wins, single write
    issue(4'hB, 1'b0, 4'h4, 4'hF, 64'h1008, 64'h77, 2'd1, 1'b0);
    wr("poprsp.n1", 1'b1, 4'h4, 64'h77, 15'h0010);
    check("poprsp.ready", 64'(w_ready), 64'd1);
    step();
    wr("poprsp.n2", 1'b0, 4'h0, 64'h0, 15'h0000);

    // cmov not taken, then taken
    issue(4'h2, 1'b0, 4'h1, 4'h5, 64'h9, 64'h0, 2'd1, 1'b0);
    wr("cmov0", 1'b0, 4'h0, 64'h0, 15'h0000);
    issue(4'h2, 1'b1, 4'h1, 4'h5, 64'h9, 64'h0, 2'd1, 1'b0);
    wr("cmov1", 1'b1, 4'h5, 64'h9, 15'h0020);
    step();

    // mrmovq into %rdi writes valM
    issue(4'h5, 1'b0, 4'h7, 4'h3, 64'h100, 64'hAB, 2'd1, 1'b0);
    wr("mrm", 1'b1, 4'h7, 64'hAB, 15'h0080);
    step();

    // back-to-back writes to r2: set beats clear
    w_valid = 1'b1;
    w_icode = 4'h6; w_rA = 4'h1; w_rB = 4'h2;
    w_valE = 64'h11; w_stat = 2'd1; w_stat_ins = 1'b0;
    step();
    w_valE = 64'h33;
    wr("b2b.n1", 1'b1, 4'h2, 64'h11, 15'h0004);
    step();
    w_valid = 1'b0;
    wr("b2b.n2", 1'b1, 4'h2, 64'h33, 15'h0004);
    step();
    wr("b2b.n3", 1'b0, 4'h0, 64'h0, 15'h0000);

    // reset in SECOND drops the M write
    issue(4'hB, 1'b0, 4'h3, 4'hF, 64'h2000, 64'h99, 2'd1, 1'b0);
    wr("rs2.n1", 1'b1, 4'h4, 64'h2000, 15'h0018);
    reset = 1'b1;
    step();
    reset = 1'b0;
    wr("rs2.n2", 1'b0, 4'h0, 64'h0, 15'h0000);
    check("rs2.addr", 64'(rf_waddr), 64'hF);
    check("rs2.ready", 64'(w_ready), 64'd1);
    step();
    check("rs2.n3.we", 64'(rf_we), 64'd0);

    // halt then irmovq: nothing written
    issue(4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, 2'd2, 1'b0);
    wr("hlt", 1'b0, 4'h0, 64'h0, 15'h0000);
    check("hlt.halted", 64'(halted), 64'd1);
    check("hlt.ready", 64'(w_ready), 64'd0);
    issue(4'h3, 1'b0, 4'hF, 4'h2, 64'h5, 64'h0, 2'd1, 1'b0);
    wr("hlt.irm", 1'b0, 4'h0, 64'h0, 15'h0000);
    check("hlt.sticky", 64'(halted), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("hlt.clr", 64'(halted), 64'd0);
    check("hlt.clr.ready", 64'(w_ready), 64'd1);

    // invalid-instruction flag also halts
    issue(4'h3, 1'b0, 4'hF, 4'h6, 64'h5, 64'h0, 2'd1, 1'b1);
    wr("ins", 1'b0, 4'h0, 64'h0, 15'h0000);
    check("ins.halted", 64'(halted), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/y86_rf_write_sched.md
Name: y86_rf_write_sched

Overview:
- Write-back scheduler for the Y86-64 pipeline's 15-entry register file.
- Accepts one retiring instruction from the W stage and decodes dstE/dstM from icode, rA, rB and cnd.
- Drives the register file's single physical write port, serialising dual-write instructions (popq, rA != %rsp) over two cycles and stalling W meanwhile.
- Suppresses all writes once a non-AOK status retires; exports a pending-write mask for the hazard/forwarding logic.

Parameters:
- DW, 64, register data width
- AW, 4, register address width; 4'hF = RNONE

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- w_valid  in  1  W stage holds a retiring instruction
- w_ready  out  1  scheduler accepts the instruction this cycle
- w_icode  in  4  Y86 icode
- w_cnd  in  1  condition result (cmovXX)
- w_rA  in  4  rA field
- w_rB  in  4  rB field
- w_valE  in  64  ALU result
- w_valM  in  64  memory read result
- w_stat  in  2  status: 1 AOK, 2 HLT, 3 ADR, 4 INS (codes as 3-bit, upper bit dropped: AOK=1, HLT=2, ADR=3; INS carried on w_stat_ins)
- w_stat_ins  in  1  invalid-instruction flag
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  write address
- rf_wdata  out  64  write data
- wr_pending  out  15  bit r set while a write to register r is scheduled but not yet committed
- halted  out  1  sticky: non-AOK instruction retired

Behaviour:
- Reset values:
  - state IDLE; rf_we=0, rf_waddr=4'hF, rf_wdata=0.
  - halted=0; wr_pending=0; hold registers cleared.
- Reset overrides everything in the same edge, including mid-sequence; a pending M write is discarded.
- Destination decode (combinational):
  - dstE = rB for irmovq(3) or OPq(6); rB for rrmovq/cmovXX(2) when w_cnd=1, else F.
  - dstE = 4 (%rsp) for call(8), ret(9), pushq(A), popq(B); otherwise F.
  - dstM = rA for mrmovq(5) and popq(B); otherwise F.
- Handshake:
  - w_ready = (state==IDLE) && !halted.
  - Accept occurs when w_valid && w_ready.
- Output timing: all rf_* outputs are registered, one-cycle latency from accept.
- States:
  - IDLE, on accept:
    - if non-AOK (w_stat!=1 or w_stat_ins): no write, set halted, stay IDLE.
    - else if exactly one of dstE/dstM != F: next cycle write that (addr, data); stay IDLE.
    - else if both != F and dstE==dstM: write M only (M has priority); stay IDLE.
    - else if both != F and distinct: next cycle write E; latch dstM/valM into hold; go to SECOND.
    - else (neither): rf_we=0.
  - SECOND: w_ready=0; next edge writes hold (dstM, valM); returns to IDLE.
- Two-write ordering is E then M, so the M value is final for any shared register.
- rf_we deasserts in any cycle without a scheduled write; rf_waddr/rf_wdata hold their last values.
- wr_pending:
  - set: on accept, set bits dstE and dstM (ignoring F).
  - clear: at the edge the corresponding write is presented on rf_we (bit cleared the cycle after presentation).
  - If set and clear coincide for the same bit, set wins.
- halted is sticky until reset.
- Inputs while w_valid=0 or w_ready=0 are ignored.

Decomposition:
- Package y86_pkg holds:
  - icode constants (IHALT..IPOPQ)
  - RNONE=4'hF, RRSP=4'h4
  - stat codes (SAOK, SHLT, SADR)
  - state enum {IDLE, SECOND}
- Sub-module y86_dst_decode: the combinational dstE/dstM decode, reused by decode-stage forwarding.

Test Plan:
- irmovq (w_icode=3, rB=2, valE=0x2A) accepted at cycle N → cycle N+1: rf_we=1, addr=2, data=0x2A; wr_pending[2] set N+1, clear N+2.
- popq (w_icode=B, rA=3, valE=0x1008, valM=0x55) →
  - N+1: write addr 4 / data 0x1008, with w_ready=0.
  - N+2: write addr 3 / data 0x55; w_ready=1 at N+2.
- popq %rsp (rA=4, valE=0x1008, valM=0x77) → single write at N+1: addr 4, data 0x77; w_ready stays 1.
- cmovXX (w_icode=2, rB=5) with w_cnd=0 → no write; with w_cnd=1, valE=9 → addr 5, data 9.
- halt (w_stat=2), then an irmovq → no write for either; halted=1 and w_ready=0 thereafter until reset.
- reset asserted during SECOND of a popq → the M write never occurs: rf_we=0, wr_pending=0, state IDLE next cycle.
